req_encoder: RTL and testbench
==============================

// Module: req_encoder
// PURPOSE
//  Request-side counterpart of the address/chip-select decoders: gathers request
//  lines from N devices (ADC, DAC, RAM, SPI, ...) and offers one request at a time
//  as a binary index. Consumer accepts each index with a VALID/ACK handshake.
//  Requests are latched (sticky) until served, so single-cycle pulses are never lost.
//  Selection is fixed-priority or round-robin.
// PARAMETERS
//  N            4  number of request lines, N >= 2; need not be a power of 2
//  ROUND_ROBIN  1  1 = rotating priority, 0 = fixed priority (index 0 highest)
//  W            $clog2(N)  localparam, IDX width
// PORTS
//  CLK      in   1  clock, all state updates on rising edge
//  N_RESET  in   1  synchronous, active-low reset
//  REQ      in   N  request lines, bit i = device i; a 1 for any single cycle sets pending[i]
//  ACK      in   1  consumer accepts the offered IDX this cycle (valid only when VALID=1)
//  VALID    out  1  IDX holds an offered request
//  IDX      out  W  binary index of the offered request, always < N
//  PENDING  out  N  registered pending-request vector
// BEHAVIOUR
//  Reset (N_RESET=0 at edge): pending=0, VALID=0, IDX=0, ptr=0, state IDLE.
//   REQ ignored while in reset. Reset mid-offer drops the offer and all pending bits.
//  Handshake: transfer = VALID & ACK at an edge. ACK with VALID=0 is ignored.
//  clr = transfer ? onehot(IDX) : 0
//  pending_next = (pending & ~clr) | REQ  (REQ on the bit being cleared in the same
//   cycle wins: bit stays pending and is offered again later)
//  sel(v) = first set bit of v searching upward from ptr, wrapping N-1 -> 0;
//   with ROUND_ROBIN=0, ptr is held at 0.
//  States: IDLE (VALID=0), OFFER (VALID=1).
//   IDLE:  pending != 0 -> OFFER, IDX <= sel(pending). Otherwise stay.
//   OFFER, no ACK: IDX and VALID held. No change even if a higher-priority REQ arrives.
//   OFFER, ACK: ptr <= (IDX == N-1) ? 0 : IDX+1 (round-robin only).
//    rem = pending & ~clr (REQ of this cycle excluded).
//    rem != 0 -> stay OFFER, IDX <= sel(rem) using the updated ptr (back-to-back).
//    rem == 0 -> IDLE, VALID <= 0, IDX held.
//  Latency: REQ high at edge k -> PENDING bit set after k -> VALID=1 after edge k+1
//   (from IDLE).
//  Throughput: one transfer per cycle while requests remain pending.
//  ptr and IDX wrap at N-1 -> 0; values >= N never appear (N=5: IDX in 0..4).
//  PENDING includes the bit currently offered until its transfer edge.
// TESTING
//  1 N_RESET=0 for 3 cycles with REQ=4'b1111 -> VALID=0, IDX=0, PENDING=0 throughout.
//  2 REQ=4'b0100 for one cycle at edge k -> PENDING=0100 after k, VALID=1/IDX=2 after
//    k+1; ACK=1 one cycle -> VALID=0, PENDING=0.
//  3 ROUND_ROBIN=0, REQ=4'b1010 pulse, ACK held 1 -> IDX=1 then IDX=3 on consecutive
//    cycles, then VALID=0.
//  4 ROUND_ROBIN=1, REQ=4'b1111 and ACK held 1 -> IDX sequence 0,1,2,3,0,1 with VALID=1
//    every cycle.
//  5 Offer IDX=2 outstanding, ACK=0 for 5 cycles, REQ=4'b0001 pulsed -> IDX stays 2;
//    after ACK, IDX=3 if ROUND_ROBIN=1, IDX=0 if ROUND_ROBIN=0.
//  6 N=5 round-robin, REQ bit4 held, transfer on IDX=4 in the same cycle -> ptr wraps
//    to 0; bit4 stays pending and is re-offered; IDX never exceeds 4.
//    Pulsing N_RESET=0 mid-offer clears VALID and PENDING.

Source files
------------

// File: rtl/req_encoder_if.sv
// Request-encoder bus interface.
// Bundles the request lines, the VALID/ACK handshake, the offered index and
// the registered pending vector between the request encoder and its consumer.
//   REQ     [N-1:0]  request lines, bit i = device i (driven by master)
//   ACK              consumer accepts the offered index (driven by master)
//   VALID            IDX holds an offered request (driven by slave)
//   IDX     [W-1:0]  binary index of the offered request (driven by slave)
//   PENDING [N-1:0]  registered pending-request vector (driven by slave)
// modport slave  : the encoder side
// modport master : the request/consumer side
interface req_encoder_if #(
  parameter int N = 4
) ();
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] REQ;
  logic         ACK;
  logic         VALID;
  logic [W-1:0] IDX;
  logic [N-1:0] PENDING;

  modport slave (
    input  REQ,
    input  ACK,
    output VALID,
    output IDX,
    output PENDING
  );

  modport master (
    output REQ,
    output ACK,
    input  VALID,
    input  IDX,
    input  PENDING
  );
endinterface

// File: rtl/req_encoder.sv
// req_encoder
// Collects request lines from N devices into a sticky pending vector and offers
// one pending request at a time as a binary index, accepted by the consumer with
// a VALID/ACK handshake. Selection is rotating (ROUND_ROBIN=1) or fixed priority
// with index 0 highest (ROUND_ROBIN=0).
// Ports:
//   CLK      clock, all state updates on the rising edge
//   N_RESET  synchronous active-low reset
//   bus      req_encoder_if.slave: REQ/ACK in, VALID/IDX/PENDING out
module req_encoder #(
  parameter int N           = 4,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic          CLK,
  input  logic          N_RESET,
  req_encoder_if.slave  bus
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t       state_q,   state_d;
  logic         valid_q,   valid_d;
  logic [W-1:0] idx_q,     idx_d;
  logic [W-1:0] ptr_q,     ptr_d;
  logic [N-1:0] pending_q, pending_d;

  logic         transfer;
  logic [N-1:0] clr;
  logic [N-1:0] rem;
  logic [W-1:0] ptr_adv;

  // First set bit of v, searching upward from start and wrapping N-1 -> 0.
  // Returns 0 when v is empty; callers only use the result for non-zero v.
  function automatic logic [W-1:0] sel(input logic [N-1:0] v,
                                       input logic [W-1:0] start);
    logic [W-1:0] r;
    logic         found;
    int           j;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && v[j]) begin
        r     = W'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign transfer = valid_q & bus.ACK;
  assign clr      = transfer ? (N'(1) << idx_q) : '0;
  // Remaining work excludes this cycle's REQ so a fresh request is never
  // offered before it has been registered into PENDING.
  assign rem      = pending_q & ~clr;
  // Pointer moves just past the served index; wraps explicitly since N need
  // not be a power of two.
  assign ptr_adv  = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    // A REQ on the bit being cleared wins: the bit stays pending.
    pending_d = rem | bus.REQ;

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = OFFER;
          valid_d = 1'b1;
          idx_d   = sel(pending_q, ptr_q);
        end
      end
      OFFER: begin
        // Without ACK the offer is frozen, even if a higher-priority
        // request shows up meanwhile.
        if (transfer) begin
          ptr_d = ROUND_ROBIN ? ptr_adv : '0;
          if (|rem) begin
            idx_d = sel(rem, ptr_d);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!N_RESET) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
    end
  end

  assign bus.VALID   = valid_q;
  assign bus.IDX     = idx_q;
  assign bus.PENDING = pending_q;

endmodule

// File: tb/tb_req_encoder.sv
// Testbench for req_encoder.
// Three instances share one clock:
//   dut_a  N=4 round-robin    driven from a vector table
//   dut_b  N=4 fixed priority hand-written sequence
//   dut_c  N=5 round-robin    hand-written sequence (wrap and mid-offer reset)
module tb_req_encoder;
  logic clk;
  logic rn_a, rn_b, rn_c;

  req_encoder_if #(.N(4)) ifa ();
  req_encoder_if #(.N(4)) ifb ();
  req_encoder_if #(.N(5)) ifc ();

  req_encoder #(.N(4), .ROUND_ROBIN(1'b1)) dut_a (.CLK(clk), .N_RESET(rn_a), .bus(ifa));
  req_encoder #(.N(4), .ROUND_ROBIN(1'b0)) dut_b (.CLK(clk), .N_RESET(rn_b), .bus(ifb));
  req_encoder #(.N(5), .ROUND_ROBIN(1'b1)) dut_c (.CLK(clk), .N_RESET(rn_c), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       ack;
    logic       exp_valid;
    logic [1:0] exp_idx;
    logic [3:0] exp_pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int r, input int rq, input int a,
                     input int v, input int i, input int p);
    vec_t e;
    e.rst_n     = 1'(r);
    e.req       = 4'(rq);
    e.ack       = 1'(a);
    e.exp_valid = 1'(v);
    e.exp_idx   = 2'(i);
    e.exp_pend  = 4'(p);
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic stepb(input int r, input int rq, input int a,
                       input int v, input int i, input int p, input string nm);
    rn_b    = 1'(r);
    ifb.REQ = 4'(rq);
    ifb.ACK = 1'(a);
    @(posedge clk);
    #1;
    chk({nm, " valid"},   32'(ifb.VALID),   32'(v));
    chk({nm, " idx"},     32'(ifb.IDX),     32'(i));
    chk({nm, " pending"}, 32'(ifb.PENDING), 32'(p));
  endtask

  task automatic stepc(input int r, input int rq, input int a,
                       input int v, input int i, input int p, input string nm);
    rn_c    = 1'(r);
    ifc.REQ = 5'(rq);
    ifc.ACK = 1'(a);
    @(posedge clk);
    #1;
    chk({nm, " valid"},   32'(ifc.VALID),   32'(v));
    chk({nm, " idx"},     32'(ifc.IDX),     32'(i));
    chk({nm, " pending"}, 32'(ifc.PENDING), 32'(p));
    chk({nm, " idx<5"},   32'(ifc.IDX < 3'd5), 32'(1));
  endtask

  initial begin
    rn_a = 1'b0; rn_b = 1'b0; rn_c = 1'b0;
    ifa.REQ = '0; ifa.ACK = 1'b0;
    ifb.REQ = '0; ifb.ACK = 1'b0;
    ifc.REQ = '0; ifc.ACK = 1'b0;

    // {rst_n, req, ack, exp_valid, exp_idx, exp_pending}
    // reset held with all requests high
    add(0, 'b1111, 0, 0, 0, 'b0000);
    add(0, 'b1111, 0, 0, 0, 'b0000);
    add(0, 'b1111, 0, 0, 0, 'b0000);
    // single pulse on device 2, latency and one transfer
    add(1, 'b0100, 0, 0, 0, 'b0100);
    add(1, 'b0000, 0, 1, 2, 'b0100);
    add(1, 'b0000, 1, 0, 2, 'b0000);
    add(1, 'b0000, 0, 0, 2, 'b0000);
    // all requests held, ACK held: 0,1,2,3,0,1 back-to-back
    add(0, 'b0000, 0, 0, 0, 'b0000);
    add(1, 'b1111, 1, 0, 0, 'b1111);
    add(1, 'b1111, 1, 1, 0, 'b1111);
    add(1, 'b1111, 1, 1, 1, 'b1111);
    add(1, 'b1111, 1, 1, 2, 'b1111);
    add(1, 'b1111, 1, 1, 3, 'b1111);
    add(1, 'b1111, 1, 1, 0, 'b1111);
    add(1, 'b1111, 1, 1, 1, 'b1111);
    // drain the remaining pending bits
    add(1, 'b0000, 0, 1, 1, 'b1111);
    add(1, 'b0000, 1, 1, 2, 'b1101);
    add(1, 'b0000, 1, 1, 3, 'b1001);
    add(1, 'b0000, 1, 1, 0, 'b0001);
    add(1, 'b0000, 1, 0, 0, 'b0000);
    add(1, 'b0000, 0, 0, 0, 'b0000);
    // offer 2 frozen while device 0 requests; rotation continues at 3
    add(0, 'b0000, 0, 0, 0, 'b0000);
    add(1, 'b1100, 0, 0, 0, 'b1100);
    add(1, 'b0000, 0, 1, 2, 'b1100);
    add(1, 'b0001, 0, 1, 2, 'b1101);
    add(1, 'b0000, 0, 1, 2, 'b1101);
    add(1, 'b0000, 0, 1, 2, 'b1101);
    add(1, 'b0000, 0, 1, 2, 'b1101);
    add(1, 'b0000, 0, 1, 2, 'b1101);
    add(1, 'b0000, 1, 1, 3, 'b1001);
    add(1, 'b0000, 1, 1, 0, 'b0001);
    add(1, 'b0000, 1, 0, 0, 'b0000);
    // reset during an offer drops it
    add(1, 'b0010, 0, 0, 0, 'b0010);
    add(1, 'b0000, 0, 1, 1, 'b0010);
    add(0, 'b0100, 1, 0, 0, 'b0000);
    add(1, 'b0000, 0, 0, 0, 'b0000);

    foreach (tbl[n]) begin
      rn_a    = tbl[n].rst_n;
      ifa.REQ = tbl[n].req;
      ifa.ACK = tbl[n].ack;
      @(posedge clk);
      #1;
      chk($sformatf("A%0d valid", n),   32'(ifa.VALID),   32'(tbl[n].exp_valid));
      chk($sformatf("A%0d idx", n),     32'(ifa.IDX),     32'(tbl[n].exp_idx));
      chk($sformatf("A%0d pending", n), 32'(ifa.PENDING), 32'(tbl[n].exp_pend));
    end

    // Fixed priority: 1010 pulse with ACK held -> 1 then 3 then idle
    stepb(0, 'b1111, 0, 0, 0, 'b0000, "B rst");
    stepb(1, 'b1010, 1, 0, 0, 'b1010, "B latch");
    stepb(1, 'b0000, 1, 1, 1, 'b1010, "B idx1");
    stepb(1, 'b0000, 1, 1, 3, 'b1000, "B idx3");
    stepb(1, 'b0000, 1, 0, 3, 'b0000, "B idle");
    // Fixed priority: offer 2 frozen, device 0 then wins after ACK
    stepb(1, 'b1100, 0, 0, 3, 'b1100, "B latch2");
    stepb(1, 'b0000, 0, 1, 2, 'b1100, "B offer2");
    stepb(1, 'b0001, 0, 1, 2, 'b1101, "B hold0");
    stepb(1, 'b0000, 0, 1, 2, 'b1101, "B hold1");
    stepb(1, 'b0000, 0, 1, 2, 'b1101, "B hold2");
    stepb(1, 'b0000, 0, 1, 2, 'b1101, "B hold3");
    stepb(1, 'b0000, 0, 1, 2, 'b1101, "B hold4");
    stepb(1, 'b0000, 1, 1, 0, 'b1001, "B idx0");
    stepb(1, 'b0000, 1, 1, 3, 'b1000, "B idx3b");
    stepb(1, 'b0000, 1, 0, 3, 'b0000, "B idle2");

    // N=5: transfer on IDX=4 with REQ bit4 re-asserted; pointer wraps to 0
    stepc(0, 'b11111, 0, 0, 0, 'b00000, "C rst");
    stepc(1, 'b10000, 0, 0, 0, 'b10000, "C latch");
    stepc(1, 'b10000, 0, 1, 4, 'b10000, "C offer4");
    stepc(1, 'b10010, 1, 0, 4, 'b10010, "C xfer4");
    stepc(1, 'b00000, 0, 1, 1, 'b10010, "C wrap");
    stepc(1, 'b00000, 1, 1, 4, 'b10000, "C reoffer4");
    stepc(1, 'b00000, 0, 1, 4, 'b10000, "C hold4");
    stepc(0, 'b00000, 0, 0, 0, 'b00000, "C midrst");
    stepc(1, 'b00000, 0, 0, 0, 'b00000, "C after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
